cv32e40px_x_result_wb: RTL and testbench
========================================

Name: cv32e40px_x_result_wb

Overview:
- Downstream neighbour of the X-interface dispatcher: consumes coprocessor result-channel transactions and commits them to the register file.
- Buffers results in a small FIFO and steals the shared RF write port only in cycles the core writeback leaves free.
- Splits dual-write results into two sequential RF writes.
- Emits a scoreboard-clear pulse to the dispatcher once each write is fully committed.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- X_DUALWRITE, 0, 1 enables 64-bit dual-write results to rd and rd|1.
- X_ID_WIDTH, 4, width of the result instruction id.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- x_result_valid_i  in  1  coprocessor result valid
- x_result_ready_o  out  1  result accepted when valid & ready
- x_result_id_i  in  X_ID_WIDTH  id of the returning instruction
- x_result_data_i  in  32*(X_DUALWRITE+1)  result data, low word first
- x_result_rd_i  in  5  destination register
- x_result_we_i  in  X_DUALWRITE+1  bit0 write rd; bit1 also write rd|1
- core_wb_we_i  in  1  core writeback owns RF write port this cycle
- rf_we_o  out  1  RF write enable (X path)
- rf_waddr_o  out  5  RF write address
- rf_wdata_o  out  32  RF write data
- sb_clr_valid_o  out  1  one-cycle pulse: scoreboard clear
- sb_clr_addr_o  out  5  register to clear (rd)
- sb_clr_dual_o  out  1  also clear rd|1
- id_err_o  out  1  sticky: result id out of order
- busy_o  out  1  FIFO non-empty or write in progress

Behaviour:
- Reset: FIFO empty, FSM IDLE, expected id = 0. All outputs 0 except x_result_ready_o = 1.
- Acceptance:
  - x_result_ready_o = ~full. It is derived from registered count only; there is no combinational path from core_wb_we_i.
  - On valid & ready, push {id, rd, we, data}.
  - Push and pop in the same cycle are legal; the count is unchanged.
- Order check:
  - At every push, compare id against expected_id, then increment expected_id modulo 2^X_ID_WIDTH.
  - On mismatch, set id_err_o (sticky until reset). The entry is still processed.
- FSM, states IDLE, WR_LO, WR_HI, operating on the FIFO head:
  - IDLE, FIFO non-empty: go to WR_LO in the next cycle. An entry pushed in cycle N is written no earlier than cycle N+1.
  - WR_LO:
    - If core_wb_we_i = 1, drive rf_we_o = 0 and hold.
    - Else drive rf_we_o = we[0] & (rd != 0), rf_waddr_o = rd, rf_wdata_o = data[31:0].
    - If X_DUALWRITE & we[1], go to WR_HI.
    - Otherwise pop; go to WR_LO if another entry is present, else IDLE.
    - Back-to-back throughput is 1 result/cycle.
  - WR_HI:
    - Stall while core_wb_we_i = 1.
    - Else write rd|1 with data[63:32], suppressed if the address is 0.
    - Pop; next state as in WR_LO.
- Scoreboard clear:
  - sb_clr_valid_o pulses in the cycle of the final write of an entry (LO, or HI for dual) when we[0] = 1 and rd != 0.
  - sb_clr_addr_o = rd; sb_clr_dual_o = we[1].
  - Entries with we[0] = 0 pop in one WR_LO cycle with no write and no pulse.
- Dual-write address: rd odd with we[1] = 1 is illegal input. The HI write goes to rd|1 = rd; this is not checked.
- Core priority: core_wb_we_i always wins. The X path never writes while it is high; data and address are held stable across stall cycles.
- Reset mid-operation: entries are discarded and no pulse is emitted. The dispatcher is reset by the same event.
- busy_o = (count != 0) | (state != IDLE).

Decomposition:
- Shared package (cv32e40px_core_v_xif_pkg): X_DUALWRITE, X_ID_WIDTH, and a packed x_result_entry_t {id, rd, we, data}.
- Sub-module cv32e40px_x_result_fifo: generic synchronous FIFO of x_result_entry_t, DEPTH entries.
  - Outputs full/empty/head.
  - No fall-through (output registered from storage).
- Top holds the FSM, arbitration, id check and clear generation.

Test Plan:
- Single result rd=5, data=0xDEADBEEF, we=1, core idle -> cycle+1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, sb_clr_valid_o=1, sb_clr_addr_o=5, sb_clr_dual_o=0.
- Same result with core_wb_we_i high for 3 cycles -> no X write for 3 cycles, outputs held, write and pulse on cycle 4; FIFO count stays 1.
- X_DUALWRITE=1, rd=6, we=2'b11, data=0x1111_2222_3333_4444:
  - Write r6=0x33334444, then r7=0x11112222.
  - Single pulse on the second write, sb_clr_dual_o=1.
- Burst of 4 results, ids 0..3, DEPTH=2, core idle:
  - Ready drops only when full.
  - All 4 written in order, one per cycle.
  - id_err_o stays 0.
- Result rd=0 we=1 -> no RF write, no pulse, popped. Then a result with id 7 when 1 is expected -> id_err_o=1, stays 1.
- Reset asserted with 2 entries queued -> next cycle busy_o=0, x_result_ready_o=1, no writes or pulses after reset release.

Source files
------------

// File: rtl/cv32e40px_core_v_xif_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40px_core_v_xif_pkg
//   Shared definitions for the X-interface result path.
//   - X_DUALWRITE / X_ID_WIDTH : default interface configuration
//   - X_ID_MAX                 : width of the id field held in a buffered
//                                entry; any configured id width must fit
//   - x_result_entry_t         : one buffered coprocessor result, sized for
//                                the widest configuration (dual write)
//   - x_hi_addr()              : destination of the second dual-write word
// ---------------------------------------------------------------------------
package cv32e40px_core_v_xif_pkg;

  localparam int X_DUALWRITE = 0;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_ID_MAX    = 8;

  typedef struct packed {
    logic [X_ID_MAX-1:0] id;
    logic [4:0]          rd;
    logic [1:0]          we;
    logic [63:0]         data;  // low word in [31:0]
  } x_result_entry_t;

  // The high word of a dual write always lands in the odd register of the pair.
  function automatic logic [4:0] x_hi_addr(input logic [4:0] rd);
    return rd | 5'd1;
  endfunction

endpackage

// File: rtl/cv32e40px_x_result_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40px_x_result_fifo
//   Synchronous FIFO of x_result_entry_t, DEPTH entries (power of two, >= 2).
//   The head is read straight from storage, so a pushed entry becomes visible
//   on head_o only after the clock edge that stores it (no fall-through).
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     push_i/data_i  write an entry (ignored when full)
//     pop_i          drop the head entry (ignored when empty)
//     full_o/empty_o occupancy flags from the registered count
//     single_o       exactly one entry stored
//     head_o         oldest stored entry
// ---------------------------------------------------------------------------
module cv32e40px_x_result_fifo
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  x_result_entry_t data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic            single_o,
  output x_result_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  x_result_entry_t mem [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;  // wraps: DEPTH is a power of two
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= data_i;
  end

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign single_o = (count_q == CW'(1));
  assign head_o   = mem[rptr_q];

endmodule

// File: rtl/cv32e40px_x_result_wb.sv
// ---------------------------------------------------------------------------
// cv32e40px_x_result_wb
//   Commits coprocessor results to the register file through the shared
//   write port, using only cycles the core writeback leaves free.
//   Ports:
//     clk_i, rst_i        clock, asynchronous active-high reset
//     x_result_*          coprocessor result channel (valid/ready handshake)
//     core_wb_we_i        core owns the RF write port this cycle
//     rf_we_o/waddr/wdata RF write from the X path
//     sb_clr_*            one-cycle scoreboard clear after the final write
//     id_err_o            sticky: a result arrived with an unexpected id
//     busy_o              entries buffered or a write in progress
// ---------------------------------------------------------------------------
module cv32e40px_x_result_wb
  import cv32e40px_core_v_xif_pkg::x_result_entry_t;
  import cv32e40px_core_v_xif_pkg::x_hi_addr;
#(
  parameter int DEPTH       = 2,
  parameter int X_DUALWRITE = cv32e40px_core_v_xif_pkg::X_DUALWRITE,
  parameter int X_ID_WIDTH  = cv32e40px_core_v_xif_pkg::X_ID_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          x_result_valid_i,
  output logic                          x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]         x_result_id_i,
  input  logic [32*(X_DUALWRITE+1)-1:0] x_result_data_i,
  input  logic [4:0]                    x_result_rd_i,
  input  logic [X_DUALWRITE:0]          x_result_we_i,
  input  logic                          core_wb_we_i,
  output logic                          rf_we_o,
  output logic [4:0]                    rf_waddr_o,
  output logic [31:0]                   rf_wdata_o,
  output logic                          sb_clr_valid_o,
  output logic [4:0]                    sb_clr_addr_o,
  output logic                          sb_clr_dual_o,
  output logic                          id_err_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  wb_state_e               state_q, state_d;
  logic [X_ID_WIDTH-1:0]   expected_id_q;
  logic                    id_err_q;

  x_result_entry_t         push_entry;
  x_result_entry_t         head;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    single;
  logic                    more;
  logic                    dual;
  logic [4:0]              hi_addr;
  logic                    unused_head_id;

  // Ready depends only on the registered count, never on core_wb_we_i.
  assign x_result_ready_o = ~full;
  assign push             = x_result_valid_i & x_result_ready_o;

  always_comb begin
    push_entry                       = '0;
    push_entry.id[X_ID_WIDTH-1:0]    = x_result_id_i;
    push_entry.rd                    = x_result_rd_i;
    push_entry.we                    = 2'(x_result_we_i);
    push_entry.data                  = 64'(x_result_data_i);
  end

  cv32e40px_x_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .data_i   (push_entry),
    .pop_i    (pop),
    .full_o   (full),
    .empty_o  (empty),
    .single_o (single),
    .head_o   (head)
  );

  // The id is only checked on entry; the buffered copy is kept for debug.
  assign unused_head_id = ^head.id;

  // A second write is needed only when the low write is enabled as well;
  // entries with we[0] = 0 retire in a single WR_LO cycle.
  assign dual    = (X_DUALWRITE != 0) & head.we[0] & head.we[1];
  assign hi_addr = x_hi_addr(head.rd);

  // After popping the head, is there still something to write next cycle?
  assign more = push | ~single;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      expected_id_q <= '0;
      id_err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        if (x_result_id_i != expected_id_q) id_err_q <= 1'b1;
        expected_id_q <= expected_id_q + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = 5'd0;
    rf_wdata_o     = 32'd0;
    sb_clr_valid_o = 1'b0;
    sb_clr_addr_o  = 5'd0;
    sb_clr_dual_o  = 1'b0;

    case (state_q)
      IDLE: begin
        // Entering WR_LO on the push edge lets the write land one cycle later.
        if (push || !empty) state_d = WR_LO;
      end

      WR_LO: begin
        // Address and data stay on the port while the core holds it.
        rf_waddr_o = head.rd;
        rf_wdata_o = head.data[31:0];
        if (!core_wb_we_i) begin
          rf_we_o = head.we[0] & (head.rd != 5'd0);
          if (dual) begin
            state_d = WR_HI;
          end else begin
            pop            = 1'b1;
            sb_clr_valid_o = head.we[0] & (head.rd != 5'd0);
            sb_clr_addr_o  = head.rd;
            sb_clr_dual_o  = head.we[1];
            state_d        = more ? WR_LO : IDLE;
          end
        end
      end

      WR_HI: begin
        rf_waddr_o = hi_addr;
        rf_wdata_o = head.data[63:32];
        if (!core_wb_we_i) begin
          rf_we_o        = (hi_addr != 5'd0);
          pop            = 1'b1;
          sb_clr_valid_o = head.rd != 5'd0;
          sb_clr_addr_o  = head.rd;
          sb_clr_dual_o  = 1'b1;
          state_d        = more ? WR_LO : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign id_err_o = id_err_q;
  assign busy_o   = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_cv32e40px_x_result_wb.sv
// ---------------------------------------------------------------------------
// tb_cv32e40px_x_result_wb
//   Self-checking bench for cv32e40px_x_result_wb (DEPTH=2, dual write on).
//   Expected RF writes and scoreboard clears are queued when a result is
//   driven; a negedge monitor pops and compares them as the DUT emits them.
//   Scenario tasks add cycle-exact inline checks.
// ---------------------------------------------------------------------------
module tb_cv32e40px_x_result_wb;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0] addr;
    logic       dual;
  } clr_t;

  logic        clk_i;
  logic        rst_i;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [3:0]  x_result_id_i;
  logic [63:0] x_result_data_i;
  logic [4:0]  x_result_rd_i;
  logic [1:0]  x_result_we_i;
  logic        core_wb_we_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        sb_clr_valid_o;
  logic [4:0]  sb_clr_addr_o;
  logic        sb_clr_dual_o;
  logic        id_err_o;
  logic        busy_o;

  wr_t  wr_q[$];
  clr_t clr_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  cv32e40px_x_result_wb #(
    .DEPTH       (2),
    .X_DUALWRITE (1),
    .X_ID_WIDTH  (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_id_i    (x_result_id_i),
    .x_result_data_i  (x_result_data_i),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .core_wb_we_i     (core_wb_we_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .sb_clr_valid_o   (sb_clr_valid_o),
    .sb_clr_addr_o    (sb_clr_addr_o),
    .sb_clr_dual_o    (sb_clr_dual_o),
    .id_err_o         (id_err_o),
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: compares every X-path write and clear pulse.
  always @(negedge clk_i) begin : monitor
    wr_t  exp_w;
    clr_t exp_c;
    if (!rst_i) begin
      if (rf_we_o === 1'b1) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL rf_write: got addr=%0d data=%h, required no write", rf_waddr_o, rf_wdata_o);
        end else begin
          exp_w = wr_q.pop_front();
          if (rf_waddr_o !== exp_w.addr || rf_wdata_o !== exp_w.data) begin
            miscompares++;
            $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     rf_waddr_o, rf_wdata_o, exp_w.addr, exp_w.data);
          end
        end
      end
      if (sb_clr_valid_o === 1'b1) begin
        vectors++;
        if (clr_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_clr: got addr=%0d dual=%b, required no pulse", sb_clr_addr_o, sb_clr_dual_o);
        end else begin
          exp_c = clr_q.pop_front();
          if (sb_clr_addr_o !== exp_c.addr || sb_clr_dual_o !== exp_c.dual) begin
            miscompares++;
            $display("FAIL sb_clr: got addr=%0d dual=%b, required addr=%0d dual=%b",
                     sb_clr_addr_o, sb_clr_dual_o, exp_c.addr, exp_c.dual);
          end
        end
      end
    end
  end

  // Reference model of what one accepted result must produce.
  task automatic expect_result(input logic [4:0] rd, input logic [1:0] we, input logic [63:0] data);
    wr_t  w;
    clr_t c;
    if (we[0] && rd != 5'd0) begin
      w.addr = rd;
      w.data = data[31:0];
      wr_q.push_back(w);
    end
    if (we[0] && we[1]) begin
      w.addr = rd | 5'd1;
      w.data = data[63:32];
      wr_q.push_back(w);
    end
    if (we[0] && rd != 5'd0) begin
      c.addr = rd;
      c.dual = we[1];
      clr_q.push_back(c);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic push_result(input logic [3:0] id, input logic [4:0] rd,
                             input logic [1:0] we, input logic [63:0] data);
    int budget = 0;
    x_result_valid_i = 1'b1;
    x_result_id_i    = id;
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    x_result_data_i  = data;
    while (x_result_ready_o !== 1'b1 && budget < 100) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (budget >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: ready=%b, required 1 within 100 cycles", x_result_ready_o);
      x_result_valid_i = 1'b0;
      return;
    end
    expect_result(rd, we, data);
    @(posedge clk_i); #1;
    x_result_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int b = 0;
    while ((busy_o === 1'b1 || wr_q.size() != 0 || clr_q.size() != 0) && b < 200) begin
      @(posedge clk_i); #1;
      b++;
    end
    vectors++;
    if (b >= 200) begin
      miscompares++;
      $display("FAIL %s_drain: busy=%b pending_writes=%0d pending_clears=%0d, required all 0",
               name, busy_o, wr_q.size(), clr_q.size());
    end
  endtask

  task automatic apply_reset();
    rst_i            = 1'b1;
    x_result_valid_i = 1'b0;
    x_result_id_i    = '0;
    x_result_rd_i    = '0;
    x_result_we_i    = '0;
    x_result_data_i  = '0;
    core_wb_we_i     = 1'b0;
    wr_q.delete();
    clr_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [48:0] got;
    logic [48:0] want;
    apply_reset();
    got  = {x_result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o,
            sb_clr_addr_o, sb_clr_dual_o, id_err_o, busy_o};
    want = {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required %h", got, want);
    end
  endtask

  task automatic test_single();
    logic [44:0] got;
    logic [44:0] want;
    apply_reset();
    push_result(4'd0, 5'd5, 2'b01, 64'h0000_0000_DEAD_BEEF);
    got  = {rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o, sb_clr_addr_o, sb_clr_dual_o};
    want = {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL single_write: got %h, required %h", got, want);
    end
    wait_drain("single");
  endtask

  task automatic test_core_stall();
    logic [40:0] got;
    logic [40:0] want;
    logic [44:0] got_w;
    logic [44:0] want_w;
    apply_reset();
    core_wb_we_i = 1'b1;
    push_result(4'd0, 5'd5, 2'b01, 64'h0000_0000_DEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk_i); #1;
      end
      got  = {rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o, x_result_ready_o, busy_o};
      want = {1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %h, required %h", k, got, want);
      end
    end
    @(posedge clk_i); #1;
    core_wb_we_i = 1'b0;
    #1;
    got_w  = {rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o, sb_clr_addr_o, sb_clr_dual_o};
    want_w = {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0};
    vectors++;
    if (got_w !== want_w) begin
      miscompares++;
      $display("FAIL stall_release: got %h, required %h", got_w, want_w);
    end
    wait_drain("stall");
  endtask

  task automatic test_dual_write();
    logic [38:0] got_lo;
    logic [38:0] want_lo;
    logic [44:0] got_hi;
    logic [44:0] want_hi;
    apply_reset();
    push_result(4'd0, 5'd6, 2'b11, 64'h1111_2222_3333_4444);
    got_lo  = {rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o};
    want_lo = {1'b1, 5'd6, 32'h3333_4444, 1'b0};
    vectors++;
    if (got_lo !== want_lo) begin
      miscompares++;
      $display("FAIL dual_lo: got %h, required %h", got_lo, want_lo);
    end
    @(posedge clk_i); #1;
    got_hi  = {rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o, sb_clr_addr_o, sb_clr_dual_o};
    want_hi = {1'b1, 5'd7, 32'h1111_2222, 1'b1, 5'd6, 1'b1};
    vectors++;
    if (got_hi !== want_hi) begin
      miscompares++;
      $display("FAIL dual_hi: got %h, required %h", got_hi, want_hi);
    end
    wait_drain("dual");
  endtask

  task automatic test_back_to_back();
    logic [38:0] got;
    logic [38:0] want;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_result(4'(i), 5'(8 + i), 2'b01, 64'(32'hCAFE_0000 + i));
      got  = {rf_we_o, rf_waddr_o, rf_wdata_o, x_result_ready_o};
      want = {1'b1, 5'(8 + i), 32'hCAFE_0000 + 32'(i), 1'b1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %h, required %h", i, got, want);
      end
    end
    wait_drain("b2b");
    vectors++;
    if (id_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_id_err: got %b, required 0", id_err_o);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    core_wb_we_i = 1'b1;
    push_result(4'd0, 5'd12, 2'b01, 64'h0000_0000_0000_1200);
    vectors++;
    if (x_result_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ready_one: got %b, required 1", x_result_ready_o);
    end
    push_result(4'd1, 5'd13, 2'b01, 64'h0000_0000_0000_1300);
    vectors++;
    if ({x_result_ready_o, busy_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL fill_ready_full: got ready/busy=%b%b, required 01", x_result_ready_o, busy_o);
    end
    core_wb_we_i = 1'b0;
    push_result(4'd2, 5'd14, 2'b01, 64'h0000_0000_0000_1400);
    push_result(4'd3, 5'd15, 2'b11, 64'h0000_1500_0000_1400);
    wait_drain("fill");
    vectors++;
    if (id_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_id_err: got %b, required 0", id_err_o);
    end
  endtask

  task automatic test_zero_and_id_err();
    apply_reset();
    push_result(4'd0, 5'd0, 2'b01, 64'h0000_0000_5555_AAAA);
    vectors++;
    if ({rf_we_o, sb_clr_valid_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_rd_write: got we/clr=%b%b, required 00", rf_we_o, sb_clr_valid_o);
    end
    @(posedge clk_i); #1;
    vectors++;
    if ({busy_o, id_err_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_rd_pop: got busy/err=%b%b, required 00", busy_o, id_err_o);
    end
    push_result(4'd7, 5'd9, 2'b01, 64'h0000_0000_0000_0999);
    vectors++;
    if (id_err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL id_err_set: got %b, required 1", id_err_o);
    end
    wait_drain("id_err");
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (id_err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL id_err_sticky: got %b, required 1", id_err_o);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    core_wb_we_i = 1'b1;
    push_result(4'd0, 5'd10, 2'b01, 64'h0000_0000_0000_0A0A);
    push_result(4'd1, 5'd11, 2'b01, 64'h0000_0000_0000_0B0B);
    vectors++;
    if ({busy_o, x_result_ready_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_queued: got busy/ready=%b%b, required 10", busy_o, x_result_ready_o);
    end
    rst_i = 1'b1;
    wr_q.delete();
    clr_q.delete();
    @(posedge clk_i); #1;
    vectors++;
    if ({busy_o, x_result_ready_o, rf_we_o, sb_clr_valid_o} !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_reset: got busy/ready/we/clr=%b%b%b%b, required 0100",
               busy_o, x_result_ready_o, rf_we_o, sb_clr_valid_o);
    end
    rst_i        = 1'b0;
    core_wb_we_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    vectors++;
    if ({busy_o, x_result_ready_o, id_err_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL mid_after_release: got busy/ready/err=%b%b%b, required 010",
               busy_o, x_result_ready_o, id_err_o);
    end
  endtask

  initial begin
    rst_i            = 1'b1;
    x_result_valid_i = 1'b0;
    core_wb_we_i     = 1'b0;
    test_reset();
    test_single();
    test_core_stall();
    test_dual_write();
    test_back_to_back();
    test_fill();
    test_zero_and_id_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
